// File: rtl/ascon_pack.sv
// Shared Ascon permutation types, round constants and mode helpers.
// Optional pb8 (8-round) mode is enabled by defining PERMUTATION_PB8_EN.
package ascon_pack;

    typedef enum logic [1:0] {
        PA      = 2'b00,
        PB      = 2'b01,
        PB8     = 2'b10,
        ILLEGAL = 2'b11
    } type_perm_mode;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } type_perm_ctrl_state;

    localparam int         ROUNDS_PA  = 12;
    localparam int         ROUNDS_PB  = 6;
    localparam int         ROUNDS_PB8 = 8;
    localparam logic [3:0] LAST_ROUND = 4'd11;

    function automatic logic mode_legal(input logic [1:0] mode);
        logic legal;
        legal = 1'b0;
        case (mode)
            PA, PB:  legal = 1'b1;
`ifdef PERMUTATION_PB8_EN
            PB8:     legal = 1'b1;
`else
            PB8:     legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // First constant index is 12 - N; pa's start is a parameter of the top.
    function automatic logic [3:0] first_round(input logic [1:0] mode,
                                               input logic [3:0] first_pa);
        logic [3:0] idx;
        idx = first_pa;
        case (mode)
            PB:      idx = 4'(ROUNDS_PA - ROUNDS_PB);
            PB8:     idx = 4'(ROUNDS_PA - ROUNDS_PB8);
            default: idx = first_pa;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/perm_round_counter.sv
// 4-bit loadable round-constant counter; saturates at LAST_ROUND and flags it.
module perm_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    output logic [3:0] count_o,
    output logic       last_o
);

    logic [3:0] count_d, count_q;

    assign last_o  = (count_q == LAST_ROUND);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && !last_o) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/permutation_control.sv
// Round sequencer for the Ascon permutation: drives select/round, flags done.
// Define PERMUTATION_PB8_EN to accept the 8-round pb8 mode (mode 10).
module permutation_control
    import ascon_pack::*;
#(
    parameter int FIRST_PA = 0
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    output logic       ready_o,
    output logic       select_o,
    output logic [3:0] round_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] FIRST_PA_IDX = 4'(FIRST_PA);

    type_perm_ctrl_state state_d, state_q;
    logic       done_q, err_d, err_q;
    logic       load, inc, last;
    logic [3:0] load_val, count, first;
    logic       legal;

    perm_round_counter u_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (load),
        .load_val_i (load_val),
        .inc_i      (inc),
        .count_o    (count),
        .last_o     (last)
    );

    assign first    = first_round(mode_i, FIRST_PA_IDX);
    assign legal    = mode_legal(mode_i);
    assign load_val = (first == LAST_ROUND) ? LAST_ROUND : first + 4'd1;
    assign ready_o  = (state_q != RUN);
    assign done_o   = done_q;
    assign err_o    = err_q;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        inc      = 1'b0;
        err_d    = 1'b0;
        select_o = 1'b1;
        round_o  = first;
        case (state_q)
            RUN: begin
                select_o = 1'b0;
                round_o  = count;
                inc      = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; a single-round permutation goes straight to DONE.
                state_d = IDLE;
                if (start_i) begin
                    if (legal) begin
                        load    = 1'b1;
                        state_d = (first == LAST_ROUND) ? DONE : RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_permutation_control.sv
// Randomized and directed bench for permutation_control against a schedule-level model.
module tb_permutation_control;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic       ready_o, select_o, done_o, err_o;
    logic [3:0] round_o;

    int checks = 0;
    int failures = 0;

    // model: an accepted permutation is a schedule indexed by k = cycles since accept
    bit m_active = 1'b0;
    int m_k = 0;
    int m_n = 0;
    int m_f = 0;
    bit m_err_pend = 1'b0;

    permutation_control #(.FIRST_PA(0)) dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .ready_o  (ready_o),
        .select_o (select_o),
        .round_o  (round_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rounds_of(input logic [1:0] m);
        case (m)
            2'b00: return 12;
            2'b01: return 6;
`ifdef PERMUTATION_PB8_EN
            2'b10: return 8;
`endif
            default: return 0;
        endcase
    endfunction

    // One clock cycle: apply inputs, check outputs on the falling edge, advance the model.
    task automatic step(input bit rst, input bit s, input logic [1:0] m);
        bit busy, exp_ready, exp_done, acc, rej;
        int n;
        resetb_i = ~rst;
        start_i  = s;
        mode_i   = m;
        @(negedge clock_i);
        busy      = m_active && (m_k >= 1) && (m_k < m_n);
        exp_ready = !busy;
        exp_done  = m_active && (m_k == m_n);
        n         = rounds_of(m);
        check("ready", {3'b0, ready_o}, {3'b0, exp_ready});
        check("done",  {3'b0, done_o},  {3'b0, exp_done});
        check("err",   {3'b0, err_o},   {3'b0, m_err_pend});
        if (busy) begin
            check("select_run", {3'b0, select_o}, 4'd0);
            check("round_run",  round_o, 4'(m_f + m_k));
        end else begin
            check("select_ld", {3'b0, select_o}, 4'd1);
            if (n != 0) check("round_ld", round_o, 4'(12 - n));
        end
        acc = exp_ready && s && (n != 0);
        rej = exp_ready && s && (n == 0);
        if (rst) begin
            m_active   = 1'b0;
            m_err_pend = 1'b0;
        end else begin
            m_err_pend = rej;
            if (acc) begin
                m_active = 1'b1;
                m_k      = 1;
                m_n      = n;
                m_f      = 12 - n;
            end else if (busy) begin
                m_k++;
            end else begin
                m_active = 1'b0;
            end
        end
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        resetb_i = 1'b0;
        start_i  = 1'b0;
        mode_i   = 2'b00;
        repeat (2) @(posedge clock_i);
        #1;
        // reset state
        step(0, 0, 2'b00);
        // pa run, then idle
        step(0, 1, 2'b00);
        repeat (14) step(0, 0, 2'b00);
        // pb, then back-to-back pa started in the pb done cycle
        step(0, 1, 2'b01);
        repeat (5) step(0, 0, 2'b01);
        step(0, 1, 2'b00);
        repeat (14) step(0, 0, 2'b00);
        // illegal modes, incl. pb8 when not configured
        step(0, 1, 2'b11);
        repeat (3) step(0, 0, 2'b00);
        step(0, 1, 2'b10);
        repeat (10) step(0, 0, 2'b00);
        // start held high through pa run
        repeat (26) step(0, 1, 2'b00);
        repeat (3) step(0, 0, 2'b00);
        // reset at the edge ending cycle 4 of a pa run
        step(0, 1, 2'b00);
        repeat (3) step(0, 0, 2'b00);
        step(1, 0, 2'b00);
        repeat (14) step(0, 0, 2'b00);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)));
        end
        repeat (14) step(0, 0, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
